coherence_ctrl_n: RTL

//  Parametrised N-CPU snooping coherence controller. Sits between CPUS icache/dcache

---
 rtl/coherence_ctrl_n.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/coherence_ctrl_n.sv
// Purpose : N-CPU snooping coherence controller between CPUS icache/dcache pairs and one
//           single-port RAM. It arbitrates I/D traffic, broadcasts snoops and performs
//           cache-to-cache transfer with RAM write-back.
// Latency : WB = ramready cycles; D read = 2 + ramready cycles; I read = ramready cycles.
// Backpressure: non-granted caches see wait=1 until served; the RAM stalls via ramready.
// Ports   : CLK/nRST (sync active-low); per-CPU flattened iREN/iaddr/iwait/iload,
//           dREN/dWEN/daddr/dstore/dwait/dload, ccwrite/cctrans in, ccwait/ccinv/ccsnoopaddr out;
//           ramREN/ramWEN/ramaddr/ramstore out, ramload/ramready in.
// Option  : define CC_STATS_EN to add 32-bit snoop_cnt / c2c_cnt event counters.
module coherence_ctrl_n #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [CPUS-1:0]          iREN,
  input  logic [CPUS*WORD_W-1:0]   iaddr,
  output logic [CPUS-1:0]          iwait,
  output logic [CPUS*WORD_W-1:0]   iload,
  input  logic [CPUS-1:0]          dREN,
  input  logic [CPUS-1:0]          dWEN,
  input  logic [CPUS*WORD_W-1:0]   daddr,
  input  logic [CPUS*WORD_W-1:0]   dstore,
  input  logic [CPUS-1:0]          ccwrite,
  input  logic [CPUS-1:0]          cctrans,
  output logic [CPUS-1:0]          dwait,
  output logic [CPUS*WORD_W-1:0]   dload,
  output logic [CPUS-1:0]          ccwait,
  output logic [CPUS-1:0]          ccinv,
  output logic [CPUS*WORD_W-1:0]   ccsnoopaddr,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [WORD_W-1:0]        ramaddr,
  output logic [WORD_W-1:0]        ramstore,
  input  logic [WORD_W-1:0]        ramload,
  input  logic                     ramready
`ifdef CC_STATS_EN
  ,
  output logic [31:0]              snoop_cnt,
  output logic [31:0]              c2c_cnt
`endif
);

  localparam int IDX_W = (CPUS > 1) ? $clog2(CPUS) : 1;
  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic [2:0] {IDLE, WB, SNOOP, RESP, C2C, MEMRD, IFETCH} state_t;

  state_t state, state_n;
  idx_t   owner, owner_n, snpe, snpe_n, dptr, iptr;
  logic   rfo, rfo_n;
  logic   d_done, i_done, done;
  logic   snoop_drive;
  logic [CPUS*WORD_W-1:0] dload_q, iload_q;

  // Requests are qualified by dREN/dWEN/iREN alone; cctrans carries no extra meaning here.
  logic unused_cctrans;
  assign unused_cctrans = ^cctrans;

  // Round-robin pick: returns {found, index}, searching upward from ptr.
  function automatic logic [IDX_W:0] rr_pick(input logic [CPUS-1:0] req, input idx_t ptr);
    logic [IDX_W:0]  r;
    logic [CPUS-1:0] sh;
    int              j;
    r = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= CPUS) j = j - CPUS;
      sh = req >> j;
      if (sh[0]) r = {1'b1, IDX_W'(j)};
    end
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] word_at(input logic [CPUS*WORD_W-1:0] v, input idx_t k);
    return WORD_W'(v >> (int'(k) * WORD_W));
  endfunction

  function automatic idx_t idx_next(input idx_t k);
    return (k == idx_t'(CPUS - 1)) ? '0 : idx_t'(k + 1'b1);
  endfunction

  logic [IDX_W:0]  wen_pick, ren_pick, ifp_pick;
  logic [CPUS-1:0] cw_sh;
  logic            snp_hit;
  idx_t            snp_pick;
  logic [WORD_W-1:0] own_daddr, own_dstore, own_iaddr, snp_dstore;

  assign wen_pick   = rr_pick(dWEN, dptr);
  assign ren_pick   = rr_pick(dREN, dptr);
  assign ifp_pick   = rr_pick(iREN, iptr);
  assign own_daddr  = word_at(daddr, owner);
  assign own_dstore = word_at(dstore, owner);
  assign own_iaddr  = word_at(iaddr, owner);
  assign snp_dstore = word_at(dstore, snpe);
  // A completion seen while reset is low must not produce a data pulse.
  assign done       = ramready & nRST;

  // Lowest-index snoopee (other than the requester) reporting a dirty copy.
  always_comb begin
    snp_hit  = 1'b0;
    snp_pick = '0;
    for (int k = CPUS - 1; k >= 0; k--) begin
      if (ccwrite[k] && (idx_t'(k) != owner)) begin
        snp_hit  = 1'b1;
        snp_pick = idx_t'(k);
      end
    end
  end

  always_comb begin
    state_n     = state;
    owner_n     = owner;
    snpe_n      = snpe;
    rfo_n       = rfo;
    d_done      = 1'b0;
    i_done      = 1'b0;
    snoop_drive = 1'b0;
    iwait       = '1;
    dwait       = '1;
    ccwait      = '0;
    ccinv       = '0;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;
    dload       = dload_q;
    iload       = iload_q;
    cw_sh       = ccwrite >> ren_pick[IDX_W-1:0];

    case (state)
      IDLE: begin
        if (wen_pick[IDX_W]) begin
          owner_n = wen_pick[IDX_W-1:0];
          state_n = WB;
        end else if (ren_pick[IDX_W]) begin
          owner_n = ren_pick[IDX_W-1:0];
          rfo_n   = cw_sh[0];
          state_n = (CPUS > 1) ? SNOOP : MEMRD;
        end else if (ifp_pick[IDX_W]) begin
          owner_n = ifp_pick[IDX_W-1:0];
          state_n = IFETCH;
        end
      end
      WB: begin
        ramWEN   = 1'b1;
        ramaddr  = own_daddr;
        ramstore = own_dstore;
        if (done) begin
          dwait[owner] = 1'b0;
          d_done       = 1'b1;
          state_n      = IDLE;
        end
      end
      SNOOP: begin
        snoop_drive = 1'b1;
        state_n     = RESP;
      end
      RESP: begin
        snoop_drive = 1'b1;
        if (snp_hit) begin
          snpe_n  = snp_pick;
          state_n = C2C;
        end else begin
          state_n = MEMRD;
        end
      end
      C2C: begin
        // Dirty line goes to the requester and back to RAM in the same transaction.
        snoop_drive = 1'b1;
        ramWEN      = 1'b1;
        ramaddr     = own_daddr;
        ramstore    = snp_dstore;
        if (done) begin
          dload[int'(owner)*WORD_W +: WORD_W] = snp_dstore;
          dwait[owner] = 1'b0;
          dwait[snpe]  = 1'b0;
          d_done       = 1'b1;
          state_n      = IDLE;
        end
      end
      MEMRD: begin
        snoop_drive = 1'b1;
        ramREN      = 1'b1;
        ramaddr     = own_daddr;
        if (done) begin
          dload[int'(owner)*WORD_W +: WORD_W] = ramload;
          dwait[owner] = 1'b0;
          d_done       = 1'b1;
          state_n      = IDLE;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = own_iaddr;
        if (done) begin
          iload[int'(owner)*WORD_W +: WORD_W] = ramload;
          iwait[owner] = 1'b0;
          i_done       = 1'b1;
          state_n      = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Snoop broadcast to every CPU except the requester, held until completion.
    if (snoop_drive) begin
      for (int k = 0; k < CPUS; k++) begin
        if (idx_t'(k) != owner) begin
          ccwait[k] = 1'b1;
          ccinv[k]  = rfo;
          ccsnoopaddr[k*WORD_W +: WORD_W] = own_daddr;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      owner   <= '0;
      snpe    <= '0;
      rfo     <= 1'b0;
      dptr    <= '0;
      iptr    <= '0;
      dload_q <= '0;
      iload_q <= '0;
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      snpe    <= snpe_n;
      rfo     <= rfo_n;
      dload_q <= dload;
      iload_q <= iload;
      if (d_done) dptr <= idx_next(owner);
      if (i_done) iptr <= idx_next(owner);
    end
  end

`ifdef CC_STATS_EN
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      snoop_cnt <= '0;
      c2c_cnt   <= '0;
    end else begin
      if (state == SNOOP)          snoop_cnt <= snoop_cnt + 32'd1;
      if (state == C2C && ramready) c2c_cnt  <= c2c_cnt + 32'd1;
    end
  end
`endif

endmodule
